// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a fixed access latency.
// A request is held by the requester until ACCESS is seen. The block answers
// with LAT cycles of BUSY followed by one ACCESS cycle. Illegal or
// out-of-range requests get a single ERROR cycle.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,     // BUSY cycles before ACCESS, 1..15
  parameter int DEPTH = 1024   // storage size in 32-bit words, power of two
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t ramstate
);

  localparam int        AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          op_reg, op_next;      // 1 = write, 0 = read
  logic [31:0]   ramload_reg;

  // Storage starts out all zero; reset never touches it.
  logic [31:0]   mem [DEPTH] = '{default: 32'h0};

  logic [29:0]   req_word;
  logic          req_any, req_both, req_range_ok, req_changed;
  logic          mem_we, mem_re;
  logic          unused_addr_bits;

  // Byte offset within the word is ignored.
  assign unused_addr_bits = ^ramaddr[1:0];
  assign req_word     = ramaddr[31:2];
  assign req_any      = ramREN | ramWEN;
  assign req_both     = ramREN & ramWEN;
  assign req_range_ok = ({2'b00, req_word} < 32'(DEPTH));
  // Only meaningful once the request is known to be legal and in range.
  assign req_changed  = (ramWEN != op_reg) || (req_word[AW-1:0] != idx_reg);

  // Next-state logic: latch the request, count latency, catch bad requests.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          if (req_both || !req_range_ok) begin
            state_next = ERR;
          end else begin
            state_next = WAIT;
            idx_next   = req_word[AW-1:0];
            op_next    = ramWEN;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req_any) begin
          state_next = IDLE;             // requester gave up, nothing written
        end else if (req_both || !req_range_ok) begin
          state_next = ERR;
        end else if (req_changed) begin
          // Arbiter switched requests: restart latency on the new one so
          // ACCESS never goes out against stale parameters.
          idx_next = req_word[AW-1:0];
          op_next  = ramWEN;
          cnt_next = CNT_LOAD;
        end else if (cnt_reg == 4'd0) begin
          state_next = ACC;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACC:     state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      op_reg    <= op_next;
    end
  end

  // Write on the closing edge of ACC; a reset on that edge cancels it.
  // Read is fetched on the edge entering ACC so data is valid all ACC cycle.
  assign mem_we = (state_reg == ACC) && op_reg && !RST;
  assign mem_re = (state_reg == WAIT) && (state_next == ACC) && !op_reg;

  // Memory write port (no reset so it maps onto block RAM).
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx_reg] <= ramstore;
    end
  end

  // Registered read port; holds its value except when a read is granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ramload_reg <= 32'h0;
    end else if (mem_re) begin
      ramload_reg <= mem[idx_reg];
    end
  end

  assign ramload = ramload_reg;

  // Status is a pure decode of the state register.
  always_comb begin
    ramstate = FREE;
    case (state_reg)
      IDLE:    ramstate = FREE;
      WAIT:    ramstate = BUSY;
      ACC:     ramstate = ACCESS;
      ERR:     ramstate = ERROR;
      default: ramstate = FREE;
    endcase
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder with LAT=2, DEPTH=1024.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  int n_chk = 0;
  int n_err = 0;

  ram_responder #(.LAT(2), .DEPTH(1024)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_st(input string tag, input ramstate_t exp);
    check(tag, 32'(ramstate), 32'(exp));
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive a request, count BUSY cycles until a terminal state, then drop it.
  task automatic xfer(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] store, output int nbusy,
                      output ramstate_t fin, output logic [31:0] ld);
    ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = store;
    nbusy = 0;
    tick();
    while (ramstate == BUSY && nbusy < 20) begin
      nbusy++;
      tick();
    end
    fin = ramstate;
    ld  = ramload;
    ramREN = 1'b0; ramWEN = 1'b0;
    tick();
    $display("txn ren=%0b wen=%0b addr=%h store=%h busy=%0d state=%0d load=%h",
             ren, wen, addr, store, nbusy, fin, ld);
    check_st("free_after_txn", FREE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          nb;
    ramstate_t   fs;
    logic [31:0] ld;

    RST = 1'b1; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = 32'h0; ramstore = 32'h0;
    tick();
    check_st("reset_state", FREE);
    check("reset_load", ramload, 32'h0);
    RST = 1'b0;
    tick();

    // Write then read back, with exact latency
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, nb, fs, ld);
    check("wr10_busy", 32'(nb), 32'd2);
    check("wr10_state", 32'(fs), 32'(ACCESS));
    check("wr10_load_held", ld, 32'h0);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, nb, fs, ld);
    check("rd10_busy", 32'(nb), 32'd2);
    check("rd10_state", 32'(fs), 32'(ACCESS));
    check("rd10_load", ld, 32'hDEADBEEF);

    // Switch of address mid-wait restarts latency
    xfer(1'b0, 1'b1, 32'h24, 32'h5, nb, fs, ld);
    check("wr24_load_held", ld, 32'hDEADBEEF);
    ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h20;
    tick();
    check_st("sw_busy1", BUSY);
    tick();
    check_st("sw_busy2", BUSY);
    xfer(1'b1, 1'b0, 32'h24, 32'h0, nb, fs, ld);
    check("sw_busy_after", 32'(nb), 32'd2);
    check("sw_state", 32'(fs), 32'(ACCESS));
    check("sw_load", ld, 32'h5);

    // Illegal request in IDLE
    xfer(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, nb, fs, ld);
    check("ill_busy", 32'(nb), 32'd0);
    check("ill_state", 32'(fs), 32'(ERROR));
    check("ill_load_held", ld, 32'h5);
    xfer(1'b1, 1'b0, 32'h0, 32'h0, nb, fs, ld);
    check("rd0_load", ld, 32'h0);

    // Illegal request arising in WAIT
    ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h10;
    tick();
    check_st("illw_busy", BUSY);
    xfer(1'b1, 1'b1, 32'h10, 32'h0, nb, fs, ld);
    check("illw_state", 32'(fs), 32'(ERROR));

    // Out of range, and the last in-range word
    xfer(1'b1, 1'b0, 32'h24, 32'h0, nb, fs, ld);
    check("rd24_load", ld, 32'h5);
    xfer(1'b1, 1'b0, 32'h1000, 32'h0, nb, fs, ld);
    check("oor_busy", 32'(nb), 32'd0);
    check("oor_state", 32'(fs), 32'(ERROR));
    check("oor_load_held", ld, 32'h5);
    xfer(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, nb, fs, ld);
    check("wrffc_state", 32'(fs), 32'(ACCESS));
    xfer(1'b1, 1'b0, 32'hFFC, 32'h0, nb, fs, ld);
    check("rdffc_load", ld, 32'hCAFEF00D);

    // Abandon a write in WAIT
    ramREN = 1'b0; ramWEN = 1'b1; ramaddr = 32'h8; ramstore = 32'h1234;
    tick();
    check_st("ab_busy", BUSY);
    ramWEN = 1'b0;
    tick();
    check_st("ab_free", FREE);
    xfer(1'b1, 1'b0, 32'h8, 32'h0, nb, fs, ld);
    check("ab_rd8_load", ld, 32'h0);

    // Request held past ACCESS is a fresh transaction
    ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h24;
    tick(); check_st("held_b1", BUSY);
    tick(); check_st("held_b2", BUSY);
    tick(); check_st("held_acc", ACCESS);
    check("held_load", ramload, 32'h5);
    tick(); check_st("held_free", FREE);
    tick(); check_st("held_again_busy", BUSY);
    ramREN = 1'b0;
    tick(); check_st("held_drop_free", FREE);
    $display("txn held read addr=00000024 load=%h", ramload);

    // Reset during the ACCESS cycle of a write
    ramREN = 1'b0; ramWEN = 1'b1; ramaddr = 32'h4; ramstore = 32'hAA;
    tick(); check_st("rst_b1", BUSY);
    tick(); check_st("rst_b2", BUSY);
    tick(); check_st("rst_acc", ACCESS);
    RST = 1'b1;
    tick();
    check_st("rst_free", FREE);
    check("rst_load", ramload, 32'h0);
    RST = 1'b0; ramWEN = 1'b0;
    tick();
    $display("txn reset during write addr=00000004 state=%0d", ramstate);
    xfer(1'b1, 1'b0, 32'h4, 32'h0, nb, fs, ld);
    check("rst_rd4_state", 32'(fs), 32'(ACCESS));
    check("rst_rd4_load", ld, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter LAT, default 2: number of BUSY cycles before ACCESS; legal range 1..15.
REQ-003 Parameter DEPTH, default 1024: storage size in 32-bit words; power of two.
REQ-004 Port CLK  input  1  system clock; all state changes on rising edge.
REQ-005 Port RST  input  1  synchronous active-high reset.
REQ-006 Port ramREN  input  1  read request; held by the requester until ACCESS is seen.
REQ-007 Port ramWEN  input  1  write request; held by the requester until ACCESS is seen.
REQ-008 Port ramaddr  input  32  byte address; bits [1:0] ignored; word index = ramaddr[31:2].
REQ-009 Port ramstore  input  32  write data.
REQ-010 Port ramload  output  32  read data.
REQ-011 Port ramstate  output  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

Function
REQ-012 States SHALL be IDLE, WAIT, ACC and ERR, with ramstate decoded from the state register only:
- IDLE -> FREE
- WAIT -> BUSY
- ACC -> ACCESS
- ERR -> ERROR
REQ-013 A request SHALL be exactly one of ramREN or ramWEN high; both high is an illegal request.
REQ-014 In IDLE with a legal, in-range request, the block SHALL:
- latch word index and op (read/write);
- load the wait counter with LAT-1;
- go to WAIT.
REQ-015 In WAIT, if the request is unchanged (same op, same word index) and the counter is 0, the block SHALL go to ACC; otherwise it SHALL decrement the counter.
REQ-016 In WAIT, a change of op or word index SHALL re-latch the new request and reload the counter with LAT-1, staying in WAIT.
- Cause: the arbiter switching from instruction to data.
- Requirement: ACCESS is never granted to stale parameters.
REQ-017 In WAIT, a deasserted request (REN=WEN=0) SHALL abandon the transaction, return to IDLE and perform no write.
REQ-018 Latency: a request first sampled in IDLE at edge 0 SHALL give BUSY for exactly LAT cycles, then ACCESS for exactly one cycle.
REQ-019 In ACC for a read, ramload SHALL equal mem[latched index] for the whole cycle.
REQ-020 In ACC for a write, the block SHALL write mem[latched index] <= ramstore on the closing edge of that cycle; ramload holds its previous value.
REQ-021 ACC SHALL always return to IDLE.
- A request still high in the following IDLE cycle is treated as a new transaction.
- A back-to-back fetch therefore costs LAT+2 cycles.
REQ-022 The following in IDLE, or arising in WAIT, SHALL go to ERR for exactly one cycle and then to IDLE, with no memory write:
- both REN and WEN high;
- word index >= DEPTH.
REQ-023 Outside ACC of a read, ramload SHALL hold its last value.
REQ-024 A read to an index written in an earlier ACC SHALL return the written data.

Reset
REQ-025 While RST is high at an edge, the block SHALL set:
- state IDLE, ramstate FREE;
- ramload 32'h0;
- counter 0;
- latched index 0, latched op read.
REQ-026 Reset asserted in WAIT or ACC SHALL discard the transaction; a write in progress SHALL NOT modify memory.
REQ-027 Memory contents SHALL NOT be affected by reset; all words SHALL be 0 at elaboration.

Verification
REQ-028 Write then read, LAT=2:
- stimulus: WEN, addr 0x10, store 0xDEADBEEF; then REN, addr 0x10;
- required: write ramstate FREE,BUSY,BUSY,ACCESS; read ACCESS cycle has ramload=0xDEADBEEF.
REQ-029 Switch mid-wait:
- stimulus: REN addr 0x20 for 2 cycles into WAIT, then addr 0x24 with mem[0x24]=0x5;
- required: BUSY restarts, 2 BUSY cycles after the switch, ACCESS shows 0x5.
REQ-030 Illegal request:
- stimulus: REN=WEN=1, addr 0x0;
- required: ERROR for one cycle, then FREE; mem[0] unchanged.
REQ-031 Out of range:
- stimulus: REN, addr 0x1000 with DEPTH=1024;
- required: ERROR for one cycle; ramload unchanged.
REQ-032 Abandon in WAIT:
- stimulus: WEN, addr 0x8, store 0x1234, dropped after 1 BUSY cycle;
- required: return to FREE; a later read of 0x8 returns 0.
REQ-033 Reset mid-write:
- stimulus: RST high during the ACCESS cycle of a write of 0xAA to 0x4;
- required: next cycle FREE, ramload=0; mem[0x4] unchanged.
